// File: rtl/mem_test_sequencer_pkg.sv
// rtl/mem_test_sequencer_pkg.sv - state encoding shared by the memory test sequencer.
package mem_test_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_test_sequencer_cycle_timer.sv
// rtl/mem_test_sequencer_cycle_timer.sv - clearable up-counter with terminal-count flag at LIMIT-1.
module mem_test_sequencer_cycle_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tc = (count_q == TW'(LIMIT - 1));

endmodule

// File: rtl/mem_test_sequencer.sv
// rtl/mem_test_sequencer.sv - preload/run/check sequencer for data memory; MEMTEST_FIRST_ERR_EN adds first-mismatch capture.
module mem_test_sequencer
  import mem_test_sequencer_pkg::*;
#(
  parameter int  DW        = 32,
  parameter int  AW        = 10,
  parameter int  NUM_WORDS = 10,
  parameter int  BASE_ADDR = 100,
  parameter int  TIMEOUT   = 1000,
  parameter int  ERRW      = 8,
  localparam int IW        = $clog2(NUM_WORDS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [IW-1:0]   vec_idx,
  input  logic [DW-1:0]   vec_init,
  input  logic [DW-1:0]   vec_exp,
  output logic            mem_own,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            cpu_reset,
  input  logic            cpu_done,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timed_out,
  output logic [ERRW-1:0] err_count
`ifdef MEMTEST_FIRST_ERR_EN
  ,
  output logic [IW-1:0]   first_err_idx,
  output logic [DW-1:0]   first_err_got,
  output logic [DW-1:0]   first_err_exp
`endif
);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            to_q, to_d;
  logic [DW-1:0]   exp_q, exp_d;
  logic            pend_q, pend_d;
  logic            timer_tc, start_ok, mismatch;

  mem_test_sequencer_cycle_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_RUN),
    .enable (state_q == ST_RUN),
    .tc     (timer_tc)
  );

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  // Read data returns one cycle after its address; exp_q travels alongside it.
  assign mismatch = pend_q && (mem_rdata != exp_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    to_d      = to_q;
    exp_d     = exp_q;
    pend_d    = 1'b0;
    vec_idx   = '0;
    mem_own   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_reset = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        busy      = 1'b1;
        mem_own   = 1'b1;
        mem_we    = 1'b1;
        vec_idx   = idx_q;
        mem_addr  = AW'(BASE_ADDR) + AW'(idx_q);
        mem_wdata = vec_init;
        if (idx_q == IW'(NUM_WORDS - 1)) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b1;
        if (cpu_done) begin
          state_d = ST_CHECK;
        end else if (timer_tc) begin
          state_d = ST_CHECK;
          to_d    = 1'b1;
        end
      end
      ST_CHECK: begin
        busy     = 1'b1;
        mem_own  = 1'b1;
        vec_idx  = idx_q;
        mem_addr = AW'(BASE_ADDR) + AW'(idx_q);
        if (mismatch && err_q != '1) err_d = err_q + 1'b1;
        if (idx_q < IW'(NUM_WORDS)) begin
          exp_d  = vec_exp;
          pend_d = 1'b1;
          idx_d  = idx_q + 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_q == '0) && !to_q;
      end
      default: ;
    endcase
    if (start_ok) begin
      state_d = ST_LOAD;
      idx_d   = '0;
      err_d   = '0;
      to_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
      exp_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      to_q    <= to_d;
      exp_q   <= exp_d;
      pend_q  <= pend_d;
    end
  end

  assign timed_out = to_q;
  assign err_count = err_q;

`ifdef MEMTEST_FIRST_ERR_EN
  logic          fe_vld_q, fe_vld_d;
  logic [IW-1:0] fe_idx_q, fe_idx_d;
  logic [DW-1:0] fe_got_q, fe_got_d, fe_exp_q, fe_exp_d;

  always_comb begin
    fe_vld_d = fe_vld_q;
    fe_idx_d = fe_idx_q;
    fe_got_d = fe_got_q;
    fe_exp_d = fe_exp_q;
    if (start_ok) begin
      fe_vld_d = 1'b0;
      fe_idx_d = '0;
      fe_got_d = '0;
      fe_exp_d = '0;
    end else if (state_q == ST_CHECK && mismatch && !fe_vld_q) begin
      fe_vld_d = 1'b1;
      fe_idx_d = idx_q - 1'b1;
      fe_got_d = mem_rdata;
      fe_exp_d = exp_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
      fe_got_q <= '0;
      fe_exp_q <= '0;
    end else begin
      fe_vld_q <= fe_vld_d;
      fe_idx_q <= fe_idx_d;
      fe_got_q <= fe_got_d;
      fe_exp_q <= fe_exp_d;
    end
  end

  assign first_err_idx = fe_idx_q;
  assign first_err_got = fe_got_q;
  assign first_err_exp = fe_exp_q;
`endif

endmodule
